// File: rtl/strt_check.sv
// strt_check: UART receiver start-bit checker.
// Flags strt_glitch when the start bit is sampled high at the last
// oversampling tick of the bit (edge_cnt == Prescale-1) inside the
// check window driven by the RX FSM. All bit timing comes from edge_cnt.
//
// Build option: define STRT_GLITCH_STICKY_EN to make the flag sticky
// for the rest of the check window once set. Undefined (default): each
// evaluation overwrites the flag with the sampled bit.
module strt_check #(
  parameter int Prescale_width = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      strt_chk_en,
  input  logic                      sampled_bit,
  input  logic [Prescale_width-1:0] Prescale,
  input  logic [Prescale_width-1:0] edge_cnt,
  output logic                      strt_glitch
);

  // Last tick index of the bit. The subtraction wraps, so Prescale = 0
  // compares against all-ones and Prescale = 1 evaluates on tick 0.
  logic [Prescale_width-1:0] last_tick;
  logic                      eval;
  logic                      strt_glitch_q;
  logic                      strt_glitch_d;

  // Evaluation strobe: enabled window and final tick of the bit.
  always_comb begin
    last_tick = Prescale - Prescale_width'(1);
    eval      = strt_chk_en && (edge_cnt == last_tick);
  end

  // Next-state for the glitch flag: clear outside the window, update at
  // the evaluation tick, hold otherwise.
  always_comb begin
    // NOTE: the hold value is assigned first so every path drives
    // strt_glitch_d; a missing default here would infer a latch.
    strt_glitch_d = strt_glitch_q;
    if (!strt_chk_en) begin
      strt_glitch_d = 1'b0;
    end else if (eval) begin
`ifdef STRT_GLITCH_STICKY_EN
      strt_glitch_d = strt_glitch_q | sampled_bit;
`else
      strt_glitch_d = sampled_bit;
`endif
    end
  end

  // Output flop with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignment for registered state so every flop
    // samples pre-edge values regardless of process ordering.
    if (!reset_n) begin
      strt_glitch_q <= 1'b0;
    end else begin
      strt_glitch_q <= strt_glitch_d;
    end
  end

  assign strt_glitch = strt_glitch_q;

endmodule

// File: tb/tb_strt_check.sv
// Self-checking bench for strt_check: directed scenarios with literal
// expectations, then randomized stimulus compared each cycle against a
// behavioural model of the start-bit rules.
module tb_strt_check;

  localparam int W = 6;

  logic         clk         = 1'b0;
  logic         reset_n     = 1'b0;
  logic         strt_chk_en = 1'b0;
  logic         sampled_bit = 1'b0;
  logic [W-1:0] Prescale    = '0;
  logic [W-1:0] edge_cnt    = '0;
  logic         strt_glitch;

  int vectors     = 0;
  int miscompares = 0;

  logic exp_glitch = 1'b0;
  bit   sticky;

  strt_check #(.Prescale_width(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .strt_chk_en(strt_chk_en),
    .sampled_bit(sampled_bit),
    .Prescale   (Prescale),
    .edge_cnt   (edge_cnt),
    .strt_glitch(strt_glitch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  // Behavioural model: the flag reflects the sampled bit at the last tick
  // of a bit ((Prescale-1) mod 64), is zero outside the window, and
  // otherwise keeps whatever the last evaluation left.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_glitch = 1'b0;
    end else if (!strt_chk_en) begin
      exp_glitch = 1'b0;
    end else if (int'(edge_cnt) == (int'(Prescale) + 63) % 64) begin
      if (sticky) exp_glitch = exp_glitch || sampled_bit;
      else        exp_glitch = sampled_bit;
    end
  end

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    check("model", strt_glitch, exp_glitch);
  end

  task automatic clear_window();
    strt_chk_en = 1'b0;
    @(negedge clk);
    check("en_drop_clear", strt_glitch, 1'b0);
    strt_chk_en = 1'b1;
  endtask

  int cnt;
  int mod;

  initial begin
`ifdef STRT_GLITCH_STICKY_EN
    sticky = 1'b1;
`else
    sticky = 1'b0;
`endif

    // Reset held with the line high and the window open.
    reset_n = 1'b0; strt_chk_en = 1'b1; sampled_bit = 1'b1; Prescale = 6'd8; edge_cnt = '0;
    #1 check("rst_async", strt_glitch, 1'b0);
    for (int i = 0; i < 8; i++) begin
      edge_cnt = 6'(i + 4);
      if (i < 3) begin
        @(negedge clk);
        check("rst_hold", strt_glitch, 1'b0);
      end
    end
    reset_n = 1'b1;
    // After release: nothing until the edge_cnt = 7 edge.
    for (int i = 0; i < 8; i++) begin
      edge_cnt = 6'(i);
      @(negedge clk);
      check("post_rst", strt_glitch, i == 7);
    end
    clear_window();

    // Clean start bit.
    sampled_bit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      edge_cnt = 6'(i);
      @(negedge clk);
      check("clean_start", strt_glitch, 1'b0);
    end

    // Short glitch at tick 3 only.
    for (int i = 0; i < 8; i++) begin
      edge_cnt = 6'(i);
      sampled_bit = (i == 3);
      @(negedge clk);
      check("short_glitch", strt_glitch, 1'b0);
    end

    // Glitch at the evaluation tick, then enable drop.
    for (int i = 0; i < 8; i++) begin
      edge_cnt = 6'(i);
      sampled_bit = (i == 7);
      @(negedge clk);
      check("glitch_eval", strt_glitch, i == 7);
    end
    strt_chk_en = 1'b0; edge_cnt = '0; sampled_bit = 1'b0;
    @(negedge clk);
    check("glitch_en_drop", strt_glitch, 1'b0);

    // Enable low: never flags.
    sampled_bit = 1'b1;
    for (int i = 0; i < 24; i++) begin
      edge_cnt = 6'(i % 8);
      @(negedge clk);
      check("en_low", strt_glitch, 1'b0);
    end

    // Prescale = 1: every enabled cycle evaluates.
    strt_chk_en = 1'b1; Prescale = 6'd1; edge_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      sampled_bit = i[0];
      @(negedge clk);
      check("pre1_follow", strt_glitch, i[0]);
    end

    // Prescale = 0: evaluation only at edge_cnt = 63.
    Prescale = '0;
    clear_window();
    sampled_bit = 1'b1;
    for (int i = 0; i < 64; i++) begin
      edge_cnt = 6'(i);
      @(negedge clk);
      check("pre0_eval63", strt_glitch, i == 63);
    end

    // 1-then-0 evaluation sequence.
    Prescale = 6'd8;
    clear_window();
    for (int i = 0; i < 16; i++) begin
      edge_cnt = 6'(i % 8);
      sampled_bit = (i == 7);
      @(negedge clk);
    end
    check("one_then_zero", strt_glitch, sticky);

    // Reset mid-window clears at once.
    clear_window();
    edge_cnt = 6'd7; sampled_bit = 1'b1;
    @(negedge clk);
    check("pre_midrst", strt_glitch, 1'b1);
    #2 reset_n = 1'b0;
    #1 check("mid_rst_async", strt_glitch, 1'b0);
    #1 reset_n = 1'b1;
    edge_cnt = '0; sampled_bit = 1'b0;
    @(negedge clk);
    check("after_mid_rst", strt_glitch, 1'b0);

    // Randomized phase; the compare process checks every cycle.
    cnt = 0; mod = 8; Prescale = 6'd8;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        Prescale = 6'($urandom_range(0, 12));
        mod = (Prescale == 0) ? 64 : int'(Prescale);
        cnt = 0;
      end
      if ($urandom_range(0, 15) == 0) cnt = int'($urandom_range(0, 63));
      else                            cnt = (cnt + 1) % mod;
      edge_cnt    = 6'(cnt);
      strt_chk_en = ($urandom_range(0, 9) != 0);
      sampled_bit = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 1'b0;
        #1 check("rand_async_rst", strt_glitch, 1'b0);
        #1 reset_n = 1'b1;
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
